// File: rtl/conv_pkg.sv
// Shared widths, saturation limits and helpers for the stride-2 convolution encoder.
package conv_pkg;

    localparam int PIX_W         = 9;
    localparam int K_W           = 12;
    localparam int BIAS_W        = 20;
    localparam int PROD_W        = PIX_W + K_W;
    localparam int ACC_W         = 25;
    localparam int SHIFT_DEFAULT = 10;
    localparam int SAT_MAX       = 255;
    localparam int SAT_MIN       = -256;

    typedef logic signed [PIX_W-1:0]  pix_t;
    typedef logic signed [K_W-1:0]    tap_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Clamp a scaled accumulator into the signed pixel range.
    function automatic pix_t sat9(input acc_t v);
        pix_t r;
        if (v > acc_t'(SAT_MAX)) begin
            r = pix_t'(SAT_MAX);
        end else if (v < acc_t'(SAT_MIN)) begin
            r = pix_t'(SAT_MIN);
        end else begin
            r = pix_t'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One-row pixel delay: reads the value stored IMG_W beats ago at the same column,
// then overwrites it with the incoming pixel.
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              de,
    input  logic [AW-1:0]     addr,
    input  logic [PIX_W-1:0]  din,
    output logic [PIX_W-1:0]  dout
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Asynchronous read returns the old contents during the write cycle.
    assign dout = mem[addr];

    // Store the current pixel only on valid beats.
    always_ff @(posedge clk) begin
        if (de) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/conv_downsample.sv
// Streaming 3x3 stride-2 convolution: IMG_W x IMG_W raster in, IMG_W/2 square raster out.
module conv_downsample
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int SHIFT = SHIFT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     de,
    input  logic signed [PIX_W-1:0]  data_in,
    input  logic signed [K_W-1:0]    k1,
    input  logic signed [K_W-1:0]    k2,
    input  logic signed [K_W-1:0]    k3,
    input  logic signed [K_W-1:0]    k4,
    input  logic signed [K_W-1:0]    k5,
    input  logic signed [K_W-1:0]    k6,
    input  logic signed [K_W-1:0]    k7,
    input  logic signed [K_W-1:0]    k8,
    input  logic signed [K_W-1:0]    k9,
    input  logic signed [BIAS_W-1:0] bias,
    output logic                     de_o,
    output logic signed [PIX_W-1:0]  data,
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);

    logic [CW-1:0] col, row;
    pix_t          lb1_out, lb2_out;
    pix_t          sr_top [2];
    pix_t          sr_mid [2];
    pix_t          sr_bot [2];
    tap_t          kk     [9];
    pix_t          win_d  [9];
    pix_t          win_q  [9];
    prod_t         prod_q [9];
    acc_t          acc;
    logic          trig, last_px, pad_top, pad_left;
    logic          v1, v2, last1, last2;

    assign kk       = '{k1, k2, k3, k4, k5, k6, k7, k8, k9};
    assign trig     = de & row[0] & col[0];
    assign last_px  = (row == CW'(IMG_W - 1)) && (col == CW'(IMG_W - 1));
    assign pad_top  = (row == CW'(1));
    assign pad_left = (col == CW'(1));

    // Raster position of the incoming pixel; wraps into the next frame seamlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (de) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == CW'(IMG_W - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    conv_line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .de   (de),
        .addr (col),
        .din  (data_in),
        .dout (lb1_out)
    );

    conv_line_buf #(.DEPTH(IMG_W)) u_lb2 (
        .clk  (clk),
        .de   (de),
        .addr (col),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    // Column history for rows row-2, row-1, row: [0] is col-1, [1] is col-2.
    always_ff @(posedge clk) begin
        if (de) begin
            sr_top[1] <= sr_top[0];
            sr_top[0] <= lb2_out;
            sr_mid[1] <= sr_mid[0];
            sr_mid[0] <= lb1_out;
            sr_bot[1] <= sr_bot[0];
            sr_bot[0] <= data_in;
        end
    end

    // Assemble the window with zero padding; stale row/column history is masked out here.
    always_comb begin
        win_d[0] = (pad_top || pad_left) ? '0 : sr_top[1];
        win_d[1] = pad_top  ? '0 : sr_top[0];
        win_d[2] = pad_top  ? '0 : lb2_out;
        win_d[3] = pad_left ? '0 : sr_mid[1];
        win_d[4] = sr_mid[0];
        win_d[5] = lb1_out;
        win_d[6] = pad_left ? '0 : sr_bot[1];
        win_d[7] = sr_bot[0];
        win_d[8] = data_in;
    end

    // Pipeline valid and end-of-frame tags; cleared on reset to drop in-flight results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            last1 <= 1'b0;
            last2 <= 1'b0;
        end else begin
            v1    <= trig;
            last1 <= trig & last_px;
            v2    <= v1;
            last2 <= last1;
        end
    end

    // S1 window capture and S2 products.
    always_ff @(posedge clk) begin
        if (trig) begin
            win_q <= win_d;
        end
        if (v1) begin
            for (int unsigned i = 0; i < 9; i++) begin
                prod_q[i] <= prod_t'(win_q[i]) * prod_t'(kk[i]);
            end
        end
    end

    // Sum of products plus bias, in accumulator width.
    always_comb begin
        acc = acc_t'(bias);
        for (int unsigned i = 0; i < 9; i++) begin
            acc = acc + acc_t'(prod_q[i]);
        end
    end

    // S3 scale, saturate and present; data holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_o       <= 1'b0;
            frame_done <= 1'b0;
            data       <= '0;
        end else begin
            de_o       <= v2;
            frame_done <= v2 & last2;
            if (v2) begin
                data <= sat9(acc >>> SHIFT);
            end
        end
    end

endmodule

// File: tb/tb_conv_downsample.sv
// Scoreboard bench for conv_downsample with a frame-level reference model.
module tb_conv_downsample;

    localparam int W  = 8;
    localparam int SH = 10;
    localparam int NO = W / 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               de;
    logic signed [8:0]  data_in;
    logic signed [11:0] k1, k2, k3, k4, k5, k6, k7, k8, k9;
    logic signed [19:0] bias;
    logic               de_o;
    logic signed [8:0]  data;
    logic               frame_done;

    conv_downsample #(.IMG_W(W), .SHIFT(SH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .de         (de),
        .data_in    (data_in),
        .k1         (k1),
        .k2         (k2),
        .k3         (k3),
        .k4         (k4),
        .k5         (k5),
        .k6         (k6),
        .k7         (k7),
        .k8         (k8),
        .k9         (k9),
        .bias       (bias),
        .de_o       (de_o),
        .data       (data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          val;
        int          last;
        int unsigned t;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulses = 0;
    int          img [W][W];
    int          kv [9];
    int          bias_i;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Convolution defined directly from the output formula, on the whole image.
    function automatic int model(input int r, input int c);
        int acc;
        acc = bias_i;
        for (int i = -1; i <= 1; i++) begin
            for (int j = -1; j <= 1; j++) begin
                if (2*r + i >= 0 && 2*c + j >= 0)
                    acc += img[2*r + i][2*c + j] * kv[(i + 1)*3 + (j + 1)];
            end
        end
        acc = acc >>> SH;
        if (acc > 255) acc = 255;
        if (acc < -256) acc = -256;
        return acc;
    endfunction

    // Monitor: every output pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (de_o === 1'b1) begin
                pulses++;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_de_o: got de_o=1 expected no output (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("data", int'($signed(data)), mon_e.val);
                    check("frame_done", int'(frame_done), mon_e.last);
                    check("latency", int'(cyc), int'(mon_e.t) + 3);
                end
            end else begin
                check("frame_done_idle", int'(frame_done), 0);
            end
        end
    end

    task automatic apply_params();
        k1 = 12'(kv[0]); k2 = 12'(kv[1]); k3 = 12'(kv[2]);
        k4 = 12'(kv[3]); k5 = 12'(kv[4]); k6 = 12'(kv[5]);
        k7 = 12'(kv[6]); k8 = 12'(kv[7]); k9 = 12'(kv[8]);
        bias = 20'(bias_i);
    endtask

    task automatic idle();
        de = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drive_px(input int y, input int x);
        exp_t e;
        de      = 1'b1;
        data_in = 9'(img[y][x]);
        if ((y % 2 == 1) && (x % 2 == 1)) begin
            e.val  = model((y - 1) / 2, (x - 1) / 2);
            e.last = (y == W - 1 && x == W - 1) ? 1 : 0;
            e.t    = cyc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        de = 1'b0;
    endtask

    task automatic send_frame(input int gap);
        for (int y = 0; y < W; y++) begin
            for (int x = 0; x < W; x++) begin
                if (gap == 1 && (y != 0 || x != 0)) idle();
                if (gap == 2) repeat ($urandom_range(0, 2)) idle();
                drive_px(y, x);
            end
        end
    endtask

    task automatic run_frames(input int gap, input int nframes);
        int p0;
        p0 = pulses;
        apply_params();
        repeat (nframes) send_frame(gap);
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("drain", q.size(), 0);
        check("pulse_count", pulses - p0, NO*NO*nframes);
    endtask

    task automatic fill(input int mode, input int v);
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = (mode == 0) ? y*W + x : (mode == 1) ? v : int'($urandom_range(0, 511)) - 256;
    endtask

    task automatic set_k(input int centre, input int others, input int b);
        for (int i = 0; i < 9; i++) kv[i] = (i == 4) ? centre : others;
        bias_i = b;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        de      = 1'b0;
        data_in = '0;
        set_k(0, 0, 0);
        apply_params();
        repeat (3) @(posedge clk);
        #1;
        check("reset_de_o", int'(de_o), 0);
        check("reset_data", int'($signed(data)), 0);
        check("reset_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp with centre tap only: picks in(2r,2c).
        fill(0, 0); set_k(1024, 0, 0);
        run_frames(0, 1);

        // Flat image, all taps 1.0: exercises top/left padding.
        fill(1, 20); set_k(1024, 1024, 0);
        run_frames(0, 1);

        // Saturation in both directions.
        fill(1, 255); set_k(2047, 0, 0);
        run_frames(0, 1);
        set_k(-2048, 0, 0);
        run_frames(0, 1);

        // Floor behaviour of the arithmetic shift via bias alone.
        fill(1, 0);
        set_k(0, 0, 1536);  run_frames(0, 1);
        set_k(0, 0, -1);    run_frames(0, 1);
        set_k(0, 0, -1024); run_frames(0, 1);

        // Alternating de gaps over two back-to-back frames.
        fill(0, 0); set_k(1024, 0, 0);
        run_frames(1, 2);

        // Random images, kernels, bias and gaps.
        for (int n = 0; n < 4; n++) begin
            fill(2, 0);
            for (int i = 0; i < 9; i++) kv[i] = int'($urandom_range(0, 4095)) - 2048;
            bias_i = int'($urandom_range(0, 1048575)) - 524288;
            run_frames(2, 2);
        end

        // Reset mid-frame after 20 beats, then a clean frame.
        fill(0, 0); set_k(1024, 0, 0);
        apply_params();
        for (int b = 0; b < 20; b++) drive_px(b / W, b % W);
        de = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midreset_de_o", int'(de_o), 0);
        check("midreset_data", int'($signed(data)), 0);
        check("midreset_frame_done", int'(frame_done), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_frames(0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
